// File: rtl/conv_kxk_ctrl_if.sv
// Configuration, stream handshakes and strobes between the KxK conv controller
// and its surroundings. The controller takes the slave view; the driver of cfg/valids takes master.
interface conv_kxk_ctrl_if #(
  parameter int CHN_WIDTH = 4,
  parameter int FMS_WIDTH = 8,
  parameter int KW        = 3
);
  logic [CHN_WIDTH-1:0] cfg_ci;
  logic [CHN_WIDTH-1:0] cfg_co;
  logic [KW-1:0]        cfg_k;
  logic                 cfg_stride;
  logic [FMS_WIDTH-1:0] cfg_ifm_size;
  logic                 start_conv;
  logic                 wgt_valid;
  logic                 ifm_valid;
  logic                 wgt_read;
  logic                 ifm_read;
  logic                 pvalid;
  logic                 ic_done;
  logic                 oc_done;
  logic                 conv_done;
  logic                 busy;
  logic                 cfg_err;

  modport slave (
    input  cfg_ci, cfg_co, cfg_k, cfg_stride, cfg_ifm_size, start_conv, wgt_valid, ifm_valid,
    output wgt_read, ifm_read, pvalid, ic_done, oc_done, conv_done, busy, cfg_err
  );

  modport master (
    output cfg_ci, cfg_co, cfg_k, cfg_stride, cfg_ifm_size, start_conv, wgt_valid, ifm_valid,
    input  wgt_read, ifm_read, pvalid, ic_done, oc_done, conv_done, busy, cfg_err
  );
endinterface

// File: rtl/conv_kxk_ctrl.sv
// Sequencer for a KxK (odd K) convolution PE array: per (oc, ic) pass it loads K weight
// groups, streams one ifm row-pass, then drains the PE pipeline before the next pass.
module conv_kxk_ctrl #(
  parameter int CHN_WIDTH = 4,
  parameter int FMS_WIDTH = 8,
  parameter int KW        = 3,
  parameter int KMAX      = 5,
  parameter int PIPE_LAT  = 2
) (
  input  logic            clk,
  input  logic            rst,
  conv_kxk_ctrl_if.slave  bus
);
  localparam int DW = $clog2(PIPE_LAT + 1);
  localparam logic [DW-1:0] DLAST = DW'(PIPE_LAT - 1);

  typedef enum logic [1:0] {IDLE, WLOAD, STREAM, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [CHN_WIDTH-1:0] ci_q, ci_d, co_q, co_d, ic_q, ic_d, oc_q, oc_d;
  logic [KW-1:0]        k_q, k_d, wcnt_q, wcnt_d;
  logic                 stride_q, stride_d, err_q, err_d;
  logic [FMS_WIDTH-1:0] size_q, size_d, col_q, col_d;
  logic [DW-1:0]        dcnt_q, dcnt_d;

  logic                 cfg_ok, wgt_acc, ifm_acc, wlast, clast, dlast, more_ic, more_oc;
  logic [FMS_WIDTH-1:0] k_m1, col_off;

  assign cfg_ok  = bus.cfg_k[0] && (bus.cfg_k <= KW'(KMAX))
                   && (32'(bus.cfg_ifm_size) >= 32'(bus.cfg_k));
  assign wgt_acc = (state_q == WLOAD) && bus.wgt_valid;
  assign ifm_acc = (state_q == STREAM) && bus.ifm_valid;
  assign wlast   = (wcnt_q == k_q - KW'(1));
  assign clast   = (col_q == size_q - FMS_WIDTH'(1));
  assign dlast   = (state_q == DRAIN) && (dcnt_q == DLAST);
  assign more_ic = (ic_q < ci_q);
  assign more_oc = (oc_q < co_q);
  // Output columns start once a full K-wide window is in; stride 2 keeps even offsets only.
  assign k_m1    = FMS_WIDTH'(k_q) - FMS_WIDTH'(1);
  assign col_off = col_q - k_m1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ci_q     <= '0;
      co_q     <= '0;
      k_q      <= '0;
      stride_q <= 1'b0;
      size_q   <= '0;
      ic_q     <= '0;
      oc_q     <= '0;
      wcnt_q   <= '0;
      col_q    <= '0;
      dcnt_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ci_q     <= ci_d;
      co_q     <= co_d;
      k_q      <= k_d;
      stride_q <= stride_d;
      size_q   <= size_d;
      ic_q     <= ic_d;
      oc_q     <= oc_d;
      wcnt_q   <= wcnt_d;
      col_q    <= col_d;
      dcnt_q   <= dcnt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start_conv && cfg_ok) state_d = WLOAD;
      WLOAD:   if (wgt_acc && wlast)         state_d = STREAM;
      STREAM:  if (ifm_acc && clast)         state_d = DRAIN;
      DRAIN:   if (dlast)                    state_d = (more_ic || more_oc) ? WLOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ci_d     = ci_q;
    co_d     = co_q;
    k_d      = k_q;
    stride_d = stride_q;
    size_d   = size_q;
    ic_d     = ic_q;
    oc_d     = oc_q;
    wcnt_d   = wcnt_q;
    col_d    = col_q;
    dcnt_d   = dcnt_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: if (bus.start_conv) begin
        if (cfg_ok) begin
          ci_d     = bus.cfg_ci;
          co_d     = bus.cfg_co;
          k_d      = bus.cfg_k;
          stride_d = bus.cfg_stride;
          size_d   = bus.cfg_ifm_size;
          ic_d     = '0;
          oc_d     = '0;
          wcnt_d   = '0;
          col_d    = '0;
          dcnt_d   = '0;
        end else begin
          err_d = 1'b1;
        end
      end
      // Counters return to 0 on their last beat so the next pass starts clean.
      WLOAD:  if (wgt_acc) wcnt_d = wlast ? '0 : wcnt_q + KW'(1);
      STREAM: if (ifm_acc) col_d = clast ? '0 : col_q + FMS_WIDTH'(1);
      DRAIN: begin
        if (dlast) begin
          dcnt_d = '0;
          if (more_ic) begin
            ic_d = ic_q + CHN_WIDTH'(1);
          end else if (more_oc) begin
            ic_d = '0;
            oc_d = oc_q + CHN_WIDTH'(1);
          end
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.wgt_read  = (state_q == WLOAD);
    bus.ifm_read  = (state_q == STREAM);
    bus.busy      = (state_q != IDLE);
    bus.pvalid    = ifm_acc && (col_q >= k_m1) && (!stride_q || !col_off[0]);
    bus.ic_done   = dlast;
    bus.oc_done   = dlast && (ic_q == ci_q);
    bus.conv_done = dlast && (ic_q == ci_q) && (oc_q == co_q);
    bus.cfg_err   = err_q;
  end
endmodule

// File: tb/tb_conv_kxk_ctrl.sv
// Directed bench for conv_kxk_ctrl: per-run cycle traces checked against hand-derived timing.
module tb_conv_kxk_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  logic [99:0] wr_t, ir_t, pv_t, icd_t, ocd_t, cd_t, bz_t, er_t;

  conv_kxk_ctrl_if #(.CHN_WIDTH(4), .FMS_WIDTH(8), .KW(3)) bus ();

  conv_kxk_ctrl #(.CHN_WIDTH(4), .FMS_WIDTH(8), .KW(3), .KMAX(5), .PIPE_LAT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int first1(input logic [99:0] v);
    for (int i = 0; i < 100; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int last1(input logic [99:0] v);
    for (int i = 99; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int ones(input logic [99:0] v);
    return $countones(v);
  endfunction

  // Cycle c is the interval after clock edge c; start_conv is sampled at edge 0.
  // mode 0: valids high, 1: wgt stall + ifm toggle, 2: extra start in cycle 5.
  task automatic run(input int k, input int s, input int size, input int ci, input int co,
                     input int ncyc, input int mode, input int rst_at);
    wr_t = '0; ir_t = '0; pv_t = '0; icd_t = '0; ocd_t = '0; cd_t = '0; bz_t = '0; er_t = '0;
    bus.cfg_k        = 3'(k);
    bus.cfg_stride   = 1'(s);
    bus.cfg_ifm_size = 8'(size);
    bus.cfg_ci       = 4'(ci);
    bus.cfg_co       = 4'(co);
    for (int c = 0; c < ncyc; c++) begin
      bus.start_conv = (c == 0) || (mode == 2 && c == 5);
      if (mode == 2 && c == 5) begin
        bus.cfg_k = 3'd1; bus.cfg_ifm_size = 8'd4; bus.cfg_ci = 4'd3;
      end
      bus.wgt_valid = (mode == 1) ? !(c == 1 || c == 2) : 1'b1;
      bus.ifm_valid = (mode == 1) ? (c % 2 == 1) : 1'b1;
      #1;
      wr_t[c] = bus.wgt_read;  ir_t[c]  = bus.ifm_read; pv_t[c] = bus.pvalid;
      icd_t[c] = bus.ic_done;  ocd_t[c] = bus.oc_done;  cd_t[c] = bus.conv_done;
      bz_t[c] = bus.busy;      er_t[c]  = bus.cfg_err;
      if (c == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_async_busy", int'(bus.busy), 0);
        chk("rst_async_ifm_read", int'(bus.ifm_read), 0);
        chk("rst_async_pvalid", int'(bus.pvalid), 0);
      end
      if (rst_at >= 0 && c == rst_at + 2) rst = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.start_conv = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_conv = 1'b0; bus.wgt_valid = 1'b1; bus.ifm_valid = 1'b1;
    bus.cfg_k = 3'd3; bus.cfg_stride = 1'b0; bus.cfg_ifm_size = 8'd8;
    bus.cfg_ci = 4'd0; bus.cfg_co = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_wgt_read", int'(bus.wgt_read), 0);
    chk("reset_ifm_read", int'(bus.ifm_read), 0);
    chk("reset_pvalid", int'(bus.pvalid), 0);
    chk("reset_strobes", int'({bus.ic_done, bus.oc_done, bus.conv_done, bus.cfg_err}), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // K=3, stride 1, 8 columns, single channel pair
    run(3, 0, 8, 0, 0, 20, 0, -1);
    chk("t1_wr_first", first1(wr_t), 1);
    chk("t1_wr_last", last1(wr_t), 3);
    chk("t1_ir_first", first1(ir_t), 4);
    chk("t1_ir_last", last1(ir_t), 11);
    chk("t1_pv_first", first1(pv_t), 6);
    chk("t1_pv_cnt", ones(pv_t), 6);
    chk("t1_icd_at", first1(icd_t), 13);
    chk("t1_ocd_at", first1(ocd_t), 13);
    chk("t1_cd_at", first1(cd_t), 13);
    chk("t1_cd_cnt", ones(cd_t), 1);
    chk("t1_busy_last", last1(bz_t), 13);

    // stride 2: columns 2, 4, 6
    run(3, 1, 8, 0, 0, 20, 0, -1);
    chk("t2_pv_cnt", ones(pv_t), 3);
    chk("t2_pv_mask", int'(pv_t[11:6]), 6'b010101);
    chk("t2_cd_at", first1(cd_t), 13);

    // two input x two output channels
    run(3, 0, 8, 1, 1, 60, 0, -1);
    chk("t3_icd_cnt", ones(icd_t), 4);
    chk("t3_icd_mask", int'(icd_t[13] & icd_t[26] & icd_t[39] & icd_t[52]), 1);
    chk("t3_ocd_cnt", ones(ocd_t), 2);
    chk("t3_ocd_mask", int'(ocd_t[26] & ocd_t[52]), 1);
    chk("t3_cd_at", first1(cd_t), 52);
    chk("t3_cd_cnt", ones(cd_t), 1);
    chk("t3_busy_last", last1(bz_t), 52);

    // stalls: wgt_valid low in cycles 1-2, ifm_valid high only on odd cycles
    run(3, 0, 8, 0, 0, 30, 1, -1);
    chk("t4_wr_cnt", ones(wr_t), 5);
    chk("t4_ir_first", first1(ir_t), 6);
    chk("t4_ir_cnt", ones(ir_t), 16);
    chk("t4_pv_cnt", ones(pv_t), 6);
    chk("t4_pv_first", first1(pv_t), 11);
    chk("t4_pv_last", last1(pv_t), 21);
    chk("t4_cd_at", first1(cd_t), 23);

    // illegal configs
    run(2, 0, 8, 0, 0, 6, 0, -1);
    chk("t5_err_c1", int'(er_t[1]), 1);
    chk("t5_err_cnt", ones(er_t), 1);
    chk("t5_wr_cnt", ones(wr_t), 0);
    chk("t5_busy_cnt", ones(bz_t), 0);
    run(5, 0, 4, 0, 0, 6, 0, -1);
    chk("t5b_err_c1", int'(er_t[1]), 1);
    chk("t5b_busy_cnt", ones(bz_t), 0);

    // start in cycle 5 ignored, latched config kept
    run(3, 0, 8, 0, 0, 20, 2, -1);
    chk("t6_pv_cnt", ones(pv_t), 6);
    chk("t6_cd_at", first1(cd_t), 13);
    chk("t6_cd_cnt", ones(cd_t), 1);
    chk("t6_err_cnt", ones(er_t), 0);

    // reset in STREAM cycle 7, then a K=1 restart
    run(3, 0, 8, 0, 0, 16, 0, 7);
    chk("t7_ir_pre", int'(ir_t[7]), 1);
    chk("t7_icd_cnt", ones(icd_t), 0);
    chk("t7_cd_cnt", ones(cd_t), 0);
    chk("t7_busy_after", ones(bz_t[15:8]), 0);
    run(1, 0, 4, 0, 0, 12, 0, -1);
    chk("t7b_pv_cnt", ones(pv_t), 4);
    chk("t7b_pv_first", first1(pv_t), 2);
    chk("t7b_cd_at", first1(cd_t), 7);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/conv_kxk_ctrl.md
Name: conv_kxk_ctrl

Overview:
Parametrised sequencing controller for the convolution kernel. It generalises the fixed 3x3 PE-array controller to a runtime-selectable odd kernel size K (1..KMAX), stride 1/2 and configurable pipeline drain. It adds valid/read handshakes on the weight and ifm streams so that upstream buffers can stall the kernel. It drives the PE array with weight-load, ifm-stream, partial-valid and channel/convolution completion strobes.

Parameters:
CHN_WIDTH, 4, width of channel-count config (encoded count minus one)
FMS_WIDTH, 8, width of ifm size config (columns per row-pass)
KW, 3, width of cfg_k
KMAX, 5, largest legal kernel size (odd)
PIPE_LAT, 2, DRAIN cycles after the last ifm beat (PE array latency), >=1

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
cfg_ci  in  CHN_WIDTH  input channels minus one
cfg_co  in  CHN_WIDTH  output channels minus one
cfg_k  in  KW  kernel size K
cfg_stride  in  1  0: stride 1, 1: stride 2
cfg_ifm_size  in  FMS_WIDTH  ifm columns per pass
start_conv  in  1  start pulse; cfg_* sampled on the same edge
wgt_valid  in  1  weight group available
ifm_valid  in  1  ifm group available
wgt_read  out  1  weight group consumed when wgt_read & wgt_valid
ifm_read  out  1  ifm group consumed when ifm_read & ifm_valid
pvalid  out  1  current accepted ifm beat produces an output column
ic_done  out  1  one-cycle pulse, input channel finished
oc_done  out  1  one-cycle pulse, output channel finished
conv_done  out  1  one-cycle pulse, whole convolution finished
busy  out  1  high in every state except IDLE
cfg_err  out  1  one-cycle pulse, start rejected

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high. While rst is high: state IDLE, all counters 0, all outputs 0.
- States are IDLE, WLOAD, STREAM, DRAIN. Outputs are decoded from registered state and counters. pvalid also depends combinationally on ifm_valid.
- IDLE, start_conv=1, legal config: latch the cfg_* fields, clear ic, oc, wcnt and col, and go to WLOAD on the next cycle.
- Legal config: cfg_k odd, 1<=cfg_k<=KMAX, cfg_ifm_size>=cfg_k.
- Illegal config: stay in IDLE and drive cfg_err=1 for exactly the next cycle.
- start_conv outside IDLE is ignored. The latched config is unaffected.
- WLOAD: wgt_read=1. wcnt increments on each accepted weight beat. The K-th accepted beat moves the FSM to STREAM.
- STREAM: ifm_read=1. col increments on each accepted ifm beat. The beat accepted at col=cfg_ifm_size-1 moves the FSM to DRAIN.
- pvalid = ifm_read & ifm_valid & (col>=K-1) & (stride==0 | (col-(K-1))[0]==0).
- pvalid pulses per pass = (ifm_size-K)/stride+1, computed with integer division.
- DRAIN: lasts exactly PIPE_LAT cycles, counted by dcnt. ic_done=1 in the final DRAIN cycle.
- In that same cycle, oc_done=1 if ic==ci_reg, and conv_done=1 if additionally oc==co_reg.
- Exit from DRAIN, next state:
  - ic<ci_reg: ic+1, go to WLOAD.
  - else if oc<co_reg: ic=0, oc+1, go to WLOAD.
  - else: go to IDLE.
- Stalls: a low valid freezes the corresponding counter. No strobes are lost and no pvalid is issued on stalled cycles.
- Counter widths:
  - ic and oc: CHN_WIDTH.
  - col: FMS_WIDTH.
  - wcnt: KW.
  - dcnt: clog2(PIPE_LAT+1).
  - No counter may wrap in normal operation. cfg_ci or cfg_co equal to all-ones is legal (full channel count).
- Reset mid-operation returns to IDLE immediately. No done pulse is produced. A fresh start_conv is accepted after reset deassertion.

Test Plan:
- K=3, stride 0, ifm_size=8, ci=co=0, both valids held high, PIPE_LAT=2, start at cycle 0:
  - wgt_read in cycles 1-3, ifm_read in cycles 4-11.
  - pvalid in cycles 6-11 (6 pulses).
  - ic_done, oc_done and conv_done together in cycle 13.
  - busy low from cycle 14.
- Same as above with stride 1: pvalid only at col 2, 4, 6 (cycles 6, 8, 10), 3 pulses. Done timing unchanged.
- ci=1, co=1, same geometry:
  - 4 ic_done pulses, 13 cycles apart.
  - oc_done with the 2nd and 4th ic_done.
  - single conv_done in cycle 52.
- ifm_valid toggling 1,0,1,0 during STREAM: ifm phase takes 16 cycles, still exactly 6 pvalid pulses. wgt_valid low for 2 cycles extends WLOAD by 2 cycles.
- Reject and ignore:
  - start with cfg_k=2 gives cfg_err=1 in cycle 1, no wgt_read, busy stays 0.
  - start with cfg_k=5 and ifm_size=4 gives cfg_err.
  - start_conv in cycle 5 of a run is ignored.
- Reset mid-run: assert rst in STREAM cycle 7, and all outputs go to 0 asynchronously with no done pulses. A restart with K=1, ifm_size=4 then gives pvalid on all 4 beats.
